// File: rtl/multipath_delay_ctrl.sv
// Triggered multi-channel delay injector: every path runs through a clocked tap line,
// and an arm/trigger FSM decides when the selected channels take the deeper tap.
module multipath_delay_ctrl #(
    parameter int CHANNELS  = 4,
    parameter int MAX_DELAY = 16,
    parameter int DLY_W     = $clog2(MAX_DELAY),
    parameter int CNT_W     = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] din,
    output logic [CHANNELS-1:0] dout,
    input  logic                arm,
    input  logic                trig,
    input  logic [DLY_W-1:0]    cfg_delay,
    input  logic [CHANNELS-1:0] cfg_chan_en,
    input  logic [CNT_W-1:0]    cfg_threshold,
    input  logic [CNT_W-1:0]    cfg_window,
    output logic                active,
    output logic [1:0]          state
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [MAX_DELAY-1:0] tap [CHANNELS];
    logic [1:0]           st;
    logic                 trig_q;
    logic                 trig_e;
    logic [CNT_W-1:0]     trig_cnt;
    logic [CNT_W-1:0]     trig_nxt;
    logic [CNT_W-1:0]     win_cnt;
    logic [CNT_W-1:0]     thr_l;
    logic [CNT_W-1:0]     win_l;
    logic [DLY_W-1:0]     d_l;
    logic [CHANNELS-1:0]  en_l;

    assign trig_e   = trig & ~trig_q;
    assign trig_nxt = trig_cnt + CNT_ONE;
    assign state    = st;
    assign active   = (st == ST_ACTIVE);

    // Tap lines shift unconditionally; only the output mux depends on the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                tap[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                tap[c] <= {tap[c][MAX_DELAY-2:0], din[c]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trig;
        end
    end

    // Dropping arm wins over every other transition, including trigger and expiry.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            st       <= ST_IDLE;
            trig_cnt <= '0;
            win_cnt  <= '0;
            thr_l    <= '0;
            win_l    <= '0;
            d_l      <= '0;
            en_l     <= '0;
        end else if (!arm) begin
            st <= ST_IDLE;
        end else begin
            case (st)
                ST_IDLE: begin
                    d_l      <= cfg_delay;
                    en_l     <= cfg_chan_en;
                    thr_l    <= cfg_threshold;
                    win_l    <= cfg_window;
                    trig_cnt <= '0;
                    win_cnt  <= '0;
                    st       <= (cfg_threshold == '0) ? ST_ACTIVE : ST_ARMED;
                end
                ST_ARMED: begin
                    if (trig_e) begin
                        trig_cnt <= trig_nxt;
                        if (trig_nxt == thr_l) begin
                            win_cnt <= '0;
                            st      <= ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    win_cnt <= win_cnt + CNT_ONE;
                    if ((win_l != '0) && (win_cnt == win_l - CNT_ONE)) begin
                        st <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    st <= ST_DONE;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        dout = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            dout[c] = (active && en_l[c]) ? tap[c][d_l] : tap[c][0];
        end
    end

endmodule

// File: tb/tb_multipath_delay_ctrl.sv
// Self-checking bench for multipath_delay_ctrl: expected outputs come from a per-cycle
// history of sampled din plus scenario timelines of when the window should be open.
module tb_multipath_delay_ctrl;

    localparam int CH = 4;
    localparam int MD = 16;
    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] din;
    logic [CH-1:0] dout;
    logic          arm;
    logic          trig;
    logic [DW-1:0] cfg_delay;
    logic [CH-1:0] cfg_chan_en;
    logic [CW-1:0] cfg_threshold;
    logic [CW-1:0] cfg_window;
    logic          active;
    logic [1:0]    state;

    int total = 0;
    int bad   = 0;
    int cyc   = 32;
    logic [CH-1:0] hist [0:8191];

    multipath_delay_ctrl #(
        .CHANNELS(CH), .MAX_DELAY(MD), .DLY_W(DW), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .dout(dout), .arm(arm), .trig(trig),
        .cfg_delay(cfg_delay), .cfg_chan_en(cfg_chan_en), .cfg_threshold(cfg_threshold),
        .cfg_window(cfg_window), .active(active), .state(state)
    );

    always #5 clk = ~clk;

    // One clock edge: log what the line captured (a reset edge empties the whole line),
    // then settle 1 time unit past the edge before anything is compared.
    task automatic tick();
        @(posedge clk);
        hist[cyc] = rst_n ? din : '0;
        if (!rst_n) begin
            for (int k = 1; k < MD; k++) hist[cyc-k] = '0;
        end
        cyc++;
        #1;
    endtask

    function automatic logic [CH-1:0] model_dout(bit act, int d, logic [CH-1:0] en);
        logic [CH-1:0] r;
        int e;
        e = cyc - 1;
        for (int c = 0; c < CH; c++) begin
            r[c] = (act && en[c]) ? hist[e-d][c] : hist[e][c];
        end
        return r;
    endfunction

    task automatic test_reset();
        logic [CH-1:0] exp_d;
        rst_n = 1'b0; din = 4'hF; arm = 1'b1; trig = 1'b0;
        cfg_delay = DW'($urandom); cfg_chan_en = CH'($urandom);
        cfg_threshold = 8'd0; cfg_window = 8'd0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (dout !== 4'h0) begin bad++; $display("[TB] FAIL reset_dout: got %h expected 0", dout); end
            total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL reset_active: got %b expected 0", active); end
            total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
        end
        rst_n = 1'b1; arm = 1'b0;
        for (int i = 0; i < 20; i++) begin
            din = CH'($urandom);
            tick();
            exp_d = model_dout(1'b0, 0, '0);
            total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL post_reset_dout: got %h expected %h", dout, exp_d); end
            total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL post_reset_state: got %0d expected 0", state); end
        end
    endtask

    task automatic test_threshold_window();
        logic [CH-1:0] exp_d;
        int exp_st;
        cfg_delay = 4'd4; cfg_chan_en = 4'b0101; cfg_threshold = 8'd3; cfg_window = 8'd5;
        arm = 1'b1; trig = 1'b0; din = CH'($urandom);
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL thr_armed: got %0d expected 1", state); end
        for (int i = 0; i <= 16; i++) begin
            trig = ((i % 4) == 0) && (i <= 8);
            din  = CH'($urandom);
            tick();
            exp_st = (i < 8) ? 1 : ((i <= 12) ? 2 : 3);
            exp_d  = model_dout(exp_st == 2, 4, 4'b0101);
            total++; if (state !== 2'(exp_st)) begin bad++; $display("[TB] FAIL thr_state i=%0d: got %0d expected %0d", i, state, exp_st); end
            total++; if (active !== (exp_st == 2)) begin bad++; $display("[TB] FAIL thr_active i=%0d: got %b expected %b", i, active, exp_st == 2); end
            total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL thr_dout i=%0d: got %h expected %h", i, dout, exp_d); end
        end
        arm = 1'b0; trig = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL thr_disarm: got %0d expected 0", state); end
    endtask

    task automatic test_edge_freeze();
        logic [CH-1:0] exp_d;
        int exp_st;
        cfg_delay = 4'd3; cfg_chan_en = 4'b1010; cfg_threshold = 8'd2; cfg_window = 8'd4;
        arm = 1'b1; trig = 1'b0; din = CH'($urandom);
        tick();
        cfg_delay = 4'd1; cfg_chan_en = 4'b0101; cfg_threshold = 8'd1; cfg_window = 8'd9;
        for (int i = 0; i < 12; i++) begin
            trig = (i < 10);
            din  = CH'($urandom);
            tick();
            total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL held_trig_state i=%0d: got %0d expected 1", i, state); end
        end
        for (int i = 0; i < 6; i++) begin
            trig = (i == 0);
            din  = CH'($urandom);
            tick();
            exp_st = (i < 4) ? 2 : 3;
            exp_d  = model_dout(exp_st == 2, 3, 4'b1010);
            total++; if (state !== 2'(exp_st)) begin bad++; $display("[TB] FAIL freeze_state i=%0d: got %0d expected %0d", i, state, exp_st); end
            total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL freeze_dout i=%0d: got %h expected %h", i, dout, exp_d); end
        end
        arm = 1'b0; trig = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL freeze_disarm: got %0d expected 0", state); end
    endtask

    task automatic test_abort();
        cfg_threshold = 8'd1; cfg_window = 8'd3; cfg_delay = 4'd2; cfg_chan_en = 4'hF;
        arm = 1'b1; trig = 1'b0; din = CH'($urandom);
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL abort_armed: got %0d expected 1", state); end
        arm = 1'b0; trig = 1'b1;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL abort_trig_state: got %0d expected 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL abort_trig_active: got %b expected 0", active); end
        trig = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL abort_trig_after: got %0d expected 0", state); end

        cfg_threshold = 8'd0; cfg_window = 8'd3;
        arm = 1'b1;
        tick();
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL abort_win_entry: got %0d expected 2", state); end
        tick();
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("[TB] FAIL abort_win_last: got %b expected 1", active); end
        arm = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL abort_win_state: got %0d expected 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL abort_win_active: got %b expected 0", active); end
    endtask

    task automatic test_random_config();
        logic [CH-1:0] exp_d;
        int d, thr, win, p, exp_st;
        logic [CH-1:0] en;
        for (int n = 0; n < 6; n++) begin
            d   = $urandom_range(0, MD-1);
            en  = CH'($urandom);
            thr = $urandom_range(1, 3);
            win = $urandom_range(1, 6);
            cfg_delay = DW'(d); cfg_chan_en = en; cfg_threshold = CW'(thr); cfg_window = CW'(win);
            arm = 1'b1; trig = 1'b0; din = CH'($urandom);
            tick();
            total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL rnd_armed n=%0d: got %0d expected 1", n, state); end
            cfg_delay = DW'($urandom); cfg_chan_en = CH'($urandom);
            p = 3 * (thr - 1);
            for (int i = 0; i <= p + win + 2; i++) begin
                trig = ((i % 3) == 0);
                din  = CH'($urandom);
                tick();
                exp_st = (i < p) ? 1 : ((i < p + win) ? 2 : 3);
                exp_d  = model_dout(exp_st == 2, d, en);
                total++; if (state !== 2'(exp_st)) begin bad++; $display("[TB] FAIL rnd_state n=%0d i=%0d: got %0d expected %0d", n, i, state, exp_st); end
                total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL rnd_dout n=%0d i=%0d: got %h expected %h", n, i, dout, exp_d); end
            end
            arm = 1'b0; trig = 1'b0;
            tick();
            total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL rnd_disarm n=%0d: got %0d expected 0", n, state); end
        end
    endtask

    task automatic test_immediate_persistent();
        logic [CH-1:0] exp_d;
        cfg_threshold = 8'd0; cfg_window = 8'd0; cfg_delay = 4'd15; cfg_chan_en = 4'hF;
        arm = 1'b1; trig = 1'b0; din = CH'($urandom);
        tick();
        total++; if (active !== 1'b1) begin bad++; $display("[TB] FAIL imm_entry: got %b expected 1", active); end
        for (int i = 0; i < 1000; i++) begin
            din  = CH'($urandom);
            trig = $urandom_range(0, 1);
            tick();
            exp_d = model_dout(1'b1, 15, 4'hF);
            total++; if (active !== 1'b1) begin bad++; $display("[TB] FAIL persist_active i=%0d: got %b expected 1", i, active); end
            total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL persist_dout i=%0d: got %h expected %h", i, dout, exp_d); end
        end
        arm = 1'b0; trig = 1'b0; din = CH'($urandom);
        tick();
        exp_d = model_dout(1'b0, 0, '0);
        total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL persist_exit_active: got %b expected 0", active); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL persist_exit_state: got %0d expected 0", state); end
        total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL persist_exit_dout: got %h expected %h", dout, exp_d); end
    endtask

    task automatic test_reset_mid_active();
        logic [CH-1:0] exp_d;
        cfg_threshold = 8'd0; cfg_window = 8'd0; cfg_delay = 4'd7; cfg_chan_en = 4'hF;
        arm = 1'b1; trig = 1'b0;
        for (int i = 0; i < 11; i++) begin
            din = CH'($urandom) | 4'h1;
            tick();
        end
        total++; if (active !== 1'b1) begin bad++; $display("[TB] FAIL mid_pre_active: got %b expected 1", active); end
        rst_n = 1'b0; din = CH'($urandom);
        tick();
        total++; if (dout !== 4'h0) begin bad++; $display("[TB] FAIL mid_reset_dout: got %h expected 0", dout); end
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL mid_reset_state: got %0d expected 0", state); end
        total++; if (active !== 1'b0) begin bad++; $display("[TB] FAIL mid_reset_active: got %b expected 0", active); end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            din = CH'($urandom) | 4'h8;
            tick();
            exp_d = model_dout(1'b1, 7, 4'hF);
            total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL mid_rearm_state i=%0d: got %0d expected 2", i, state); end
            total++; if (dout !== exp_d) begin bad++; $display("[TB] FAIL mid_rearm_dout i=%0d: got %h expected %h", i, dout, exp_d); end
            if (i < 7) begin
                total++; if (dout !== 4'h0) begin bad++; $display("[TB] FAIL mid_flush i=%0d: got %h expected 0", i, dout); end
            end
        end
        arm = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL mid_disarm: got %0d expected 0", state); end
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) hist[i] = '0;
        rst_n = 1'b0; din = '0; arm = 1'b0; trig = 1'b0;
        cfg_delay = '0; cfg_chan_en = '0; cfg_threshold = '0; cfg_window = '0;
        $display("[TB] starting multipath_delay_ctrl bench");
        test_reset();
        test_threshold_window();
        test_edge_freeze();
        test_abort();
        test_random_config();
        test_immediate_persistent();
        test_reset_mid_active();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multipath_delay_ctrl.md
# multipath_delay_ctrl

Parametrised, triggered multi-channel delay injector: the sequential successor to the fixed combinational delay chains. Each of CHANNELS signal paths passes through a clocked tap line. A selected subset is delayed by a programmable number of clock cycles, but only while an arm/trigger state machine is in its ACTIVE window. Outside that window every path sees the minimum one-cycle latency. The block sits inline on the target paths; the control inputs come from the test/injection controller.

## Interface
- CHANNELS, 4, number of independent data paths
- MAX_DELAY, 16, tap-line depth; maximum extra delay is MAX_DELAY-1 cycles
- DLY_W, $clog2(MAX_DELAY), width of cfg_delay
- CNT_W, 8, width of trigger threshold and window counters

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset; synchronous, active-low
- din  in  CHANNELS  data paths in
- dout  out  CHANNELS  data paths out
- arm  in  1  level; 1 = arm or stay armed, 0 = return to IDLE
- trig  in  1  trigger source; rising edges are counted
- cfg_delay  in  DLY_W  tap select d when active
- cfg_chan_en  in  CHANNELS  channels that are delayed when active
- cfg_threshold  in  CNT_W  trigger edges needed before ACTIVE; 0 = immediate
- cfg_window  in  CNT_W  ACTIVE length in cycles; 0 = persistent
- active  out  1  1 exactly while state is ACTIVE
- state  out  2  IDLE=0, ARMED=1, ACTIVE=2, DONE=3

## Operation
- Tap line per channel: tap[c][0] <= din[c]; tap[c][k] <= tap[c][k-1]. It shifts every cycle regardless of state.
- dout[c] = (active && en_l[c]) ? tap[c][d_l] : tap[c][0]. This is a combinational mux from registers.
- Config is latched into d_l, en_l, thr_l, win_l on the IDLE->(ARMED|ACTIVE) transition. cfg_* changes while not in IDLE are ignored.
- Trigger edge: trig_e = trig & ~trig_q, where trig_q is trig registered. trig_q updates in all states.
- FSM transitions (arm=0 returns to IDLE from every state and has priority):
  - IDLE: if arm=1, latch cfg and clear trig_cnt and win_cnt. Go to ACTIVE if cfg_threshold==0, else to ARMED.
  - ARMED: on trig_e, trig_cnt++. If trig_cnt+1==thr_l, go to ACTIVE and clear win_cnt. Edges in other states are not counted.
  - ACTIVE: win_cnt++ each cycle. If win_l!=0 and win_cnt==win_l-1, go to DONE. If win_l==0, stay until arm=0.
  - DONE: hold. Re-triggering requires arm to drop and re-assert.
- Tap switching is instantaneous on ACTIVE entry and exit. Duplicated samples (entry) and dropped samples (exit) are expected and are not errors.

## Timing
- Reset values: tap lines all 0, trig_q=0, counters 0, state=IDLE. Consequently dout=0, active=0, state=0 on the cycle after rst_n is sampled low. Reset mid-operation (any state) aborts at the next edge; there is no partial hold.
- Latency is 1 cycle for inactive or unselected channels and 1+d cycles for selected channels while active. d ranges 0..MAX_DELAY-1.
- arm high at edge t in IDLE gives state=ARMED (or ACTIVE) at t+1.
- The thr_l-th trig edge sampled at edge t gives active=1 at t+1.
- ACTIVE lasts exactly win_l cycles, then DONE.
- arm low at edge t gives state=IDLE and active=0 at t+1, overriding a simultaneous trig edge or window expiry.
- A trig held high counts once. trig high on the cycle arm rises is not counted unless trig_q was 0 on the following ARMED cycle's edge.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with din=4'hF and arm=1. Require dout=0, active=0, state=0. After release with arm=0, require dout[t]=din[t-1].
- Threshold/window: cfg_delay=4, cfg_chan_en=4'b0101, cfg_threshold=3, cfg_window=5, arm=1, then 3 single-cycle trig pulses 4 cycles apart. Require state=1 until the 3rd pulse, active=1 for exactly 5 cycles starting the next cycle, then state=3. During ACTIVE, dout[0] and dout[2] lag din by 5 cycles; dout[1] and dout[3] lag by 1.
- Immediate/persistent: cfg_threshold=0, cfg_window=0, cfg_delay=15, cfg_chan_en=4'hF. Require active=1 the cycle after arm rises, held for 1000 cycles with 16-cycle latency on all channels. Drop arm: active=0 and state=0 on the next cycle.
- Edge counting and config freeze: trig held high for 10 cycles counts as 1 edge (cfg_threshold=2 stays ARMED). Changing cfg_delay to 1 while ARMED has no effect; the latched delay is still applied.
- Abort priority: deassert arm on the same cycle as the final trig edge and on the same cycle as window expiry. Both must give IDLE, never ACTIVE or DONE.
- Reset mid-ACTIVE with d=7: rst_n=0 for 1 cycle. Next cycle dout=0 and state=0, and all taps are flushed (dout=0 until new din propagates).
